// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt arbiter: register offsets, FSM state encoding,
// the source-count limit check and the lowest-index priority helper.
// Optional feature macro: INTC_NEST_EN adds the nested-preemption states.
package intc_pkg;

    localparam int unsigned N_SRC_MAX = 8;

    // Word offsets, Dev_add[3:2]
    localparam logic [1:0] INTC_ENABLE  = 2'd0;
    localparam logic [1:0] INTC_PENDING = 2'd1;
    localparam logic [1:0] INTC_EDGE    = 2'd2;
    localparam logic [1:0] INTC_CUR     = 2'd3;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReq     = 3'd1,
`ifdef INTC_NEST_EN
        StService = 3'd2,
        StNestReq = 3'd3,
        StNested  = 3'd4
`else
        StService = 3'd2
`endif
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } prio_t;

    function automatic bit n_src_ok(input int unsigned n, input int unsigned id_w);
        return (n >= 1) && (n <= N_SRC_MAX) && (id_w >= 1) && ((1 << id_w) >= n);
    endfunction

    // Lowest set index wins; scanning downwards lets the lowest hit overwrite the rest.
    function automatic prio_t prio_first(input logic [N_SRC_MAX-1:0] vec);
        prio_t r;
        r = '0;
        for (int i = N_SRC_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intc_if.sv
// Device-side bundle of the interrupt arbiter: IRQ lines, bridge register port and the
// int_req/int_id/int_ack handshake to CP0.
interface intc_if #(
    parameter int unsigned N_SRC = 6,
    parameter int unsigned ID_W  = 3
);
    logic [N_SRC-1:0] src_irq;
    logic             reg_we;
    logic [1:0]       reg_addr;
    logic [31:0]      reg_wdata;
    logic [31:0]      reg_rdata;
    logic             int_req;
    logic [ID_W-1:0]  int_id;
    logic             int_ack;
    logic             busy;

    modport slave (
        input  src_irq, reg_we, reg_addr, reg_wdata, int_ack,
        output reg_rdata, int_req, int_id, busy
    );

    modport master (
        output src_irq, reg_we, reg_addr, reg_wdata, int_ack,
        input  reg_rdata, int_req, int_id, busy
    );
endinterface

// File: rtl/intc_prio_enc.sv
// Parameterised lowest-index priority encoder; idx is zero-extended to W bits.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int unsigned N = 6,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [N_SRC_MAX-1:0] vec_ext;
    prio_t                res;

    // Pad to the helper's fixed width and pick the winner.
    always_comb begin
        vec_ext        = '0;
        vec_ext[N-1:0] = vec;
        res            = prio_first(vec_ext);
        found          = res.found;
        idx            = W'(res.idx);
    end
endmodule

// File: rtl/intc_arbiter.sv
// Interrupt arbiter between device IRQ lines and CP0: register file, edge detect,
// request/service FSM. Optional feature macro: INTC_NEST_EN (one level of preemption).
module intc_arbiter
    import intc_pkg::*;
#(
    parameter int unsigned N_SRC = 6,
    parameter int unsigned ID_W  = 3
) (
    input logic   clk,
    input logic   reset,
    intc_if.slave bus
);
    if (!n_src_ok(N_SRC, ID_W)) begin : g_param_check
        $error("intc_arbiter: need 1 <= N_SRC <= 8 and 2**ID_W >= N_SRC");
    end

    state_e state_q, state_d;

    logic [N_SRC-1:0] enable_q, edge_q, pending_q, src_q;
    logic [N_SRC-1:0] eligible, rise, w1c, ack_clr, pending_d;
    logic [ID_W-1:0]  cur_id_q, win_idx;
    logic             win_found, req, busy, ack_taken, eoi, wr_enable, wr_pending, wr_edge;
    logic [31:0]      rdata;
    logic             unused_wdata;

`ifdef INTC_NEST_EN
    logic [ID_W-1:0] save_id_q;
    logic            preempt;
`endif

    assign eligible   = pending_q & enable_q;
    assign wr_enable  = bus.reg_we && (bus.reg_addr == INTC_ENABLE);
    assign wr_pending = bus.reg_we && (bus.reg_addr == INTC_PENDING);
    assign wr_edge    = bus.reg_we && (bus.reg_addr == INTC_EDGE);
    assign eoi        = bus.reg_we && (bus.reg_addr == INTC_CUR);
    // An ack only counts while a request is actually on the wire.
    assign ack_taken  = bus.int_ack && req;

    assign rise    = bus.src_irq & ~src_q;
    assign w1c     = wr_pending ? bus.reg_wdata[N_SRC-1:0] : '0;
    assign ack_clr = ack_taken ? (N_SRC'(1) << win_idx) : '0;
    // Edge bits: set beats clear. Level bits: plain registered copy of the line.
    assign pending_d = (edge_q & ((pending_q & ~w1c & ~ack_clr) | rise))
                     | (~edge_q & bus.src_irq);

    assign unused_wdata = ^bus.reg_wdata[31:N_SRC];

    intc_prio_enc #(
        .N (N_SRC),
        .W (ID_W)
    ) u_prio_enc (
        .vec   (eligible),
        .found (win_found),
        .idx   (win_idx)
    );

`ifdef INTC_NEST_EN
    assign preempt = win_found && (win_idx < cur_id_q);
`endif

    // Register file, source history and pending capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            src_q     <= '0;
        end else begin
            src_q     <= bus.src_irq;
            pending_q <= pending_d;
            if (wr_enable) enable_q <= bus.reg_wdata[N_SRC-1:0];
            if (wr_edge)   edge_q   <= bus.reg_wdata[N_SRC-1:0];
        end
    end

    // In-service id: captured on ack; a nested EOI restores the preempted id.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_id_q  <= '0;
`ifdef INTC_NEST_EN
            save_id_q <= '0;
`endif
        end else if (ack_taken) begin
            cur_id_q <= win_idx;
`ifdef INTC_NEST_EN
            if (state_q == StNestReq) save_id_q <= cur_id_q;
        end else if (eoi && (state_q == StNested)) begin
            cur_id_q <= save_id_q;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next state; an ack beats a same-cycle EOI.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (win_found) state_d = StReq;
            StReq: begin
                if (ack_taken)       state_d = StService;
                else if (!win_found) state_d = StIdle;
            end
            StService: begin
                if (eoi)          state_d = StIdle;
`ifdef INTC_NEST_EN
                else if (preempt) state_d = StNestReq;
`endif
            end
`ifdef INTC_NEST_EN
            StNestReq: begin
                if (ack_taken)     state_d = StNested;
                else if (eoi)      state_d = StIdle;
                else if (!preempt) state_d = StService;
            end
            StNested: if (eoi) state_d = StService;
`endif
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req  = 1'b0;
        busy = 1'b0;
        unique case (state_q)
            StReq:     req  = 1'b1;
            StService: busy = 1'b1;
`ifdef INTC_NEST_EN
            StNestReq: begin
                req  = 1'b1;
                busy = 1'b1;
            end
            StNested:  busy = 1'b1;
`endif
            default: ;
        endcase
    end

    // Combinational read mux; reserved bits read as zero.
    always_comb begin
        rdata = '0;
        case (bus.reg_addr)
            INTC_ENABLE:  rdata[N_SRC-1:0] = enable_q;
            INTC_PENDING: rdata[N_SRC-1:0] = pending_q;
            INTC_EDGE:    rdata[N_SRC-1:0] = edge_q;
            INTC_CUR: begin
                if (busy) begin
                    rdata[31]       = 1'b1;
                    rdata[ID_W-1:0] = cur_id_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.int_req   = req;
    assign bus.int_id    = req ? win_idx : '0;
    assign bus.busy      = busy;
    assign bus.reg_rdata = rdata;

endmodule

// File: tb/tb_intc_arbiter.sv
// Directed bench for intc_arbiter: one table row per clock cycle (inputs driven on the
// falling edge, outputs compared 1 time unit later), then a hand-written nesting sequence
// whose expectations follow INTC_NEST_EN.
module tb_intc_arbiter;
    localparam int unsigned N_SRC = 6;
    localparam int unsigned ID_W  = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    intc_if #(.N_SRC(N_SRC), .ID_W(ID_W)) bus ();

    intc_arbiter #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  src;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        ack;
        logic        req;
        logic [2:0]  id;
        logic        busy;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic [5:0] src, input logic we,
                                input logic [1:0] addr, input logic [31:0] wdata,
                                input logic ack, input logic req, input logic [2:0] id,
                                input logic busy, input logic [31:0] rdata);
        vec_t v;
        v.rst = rst; v.src = src; v.we = we; v.addr = addr; v.wdata = wdata; v.ack = ack;
        v.req = req; v.id = id; v.busy = busy; v.rdata = rdata;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        reset         = v.rst;
        bus.src_irq   = v.src;
        bus.reg_we    = v.we;
        bus.reg_addr  = v.addr;
        bus.reg_wdata = v.wdata;
        bus.int_ack   = v.ack;
        #1;
        n_vec++;
        if (bus.int_req !== v.req || bus.int_id !== v.id || bus.busy !== v.busy ||
            bus.reg_rdata !== v.rdata) begin
            n_bad++;
            $display("FAIL %s: got req=%b id=%0d busy=%b rdata=%h, want req=%b id=%0d busy=%b rdata=%h",
                     name, bus.int_req, bus.int_id, bus.busy, bus.reg_rdata,
                     v.req, v.id, v.busy, v.rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        //                 rst src   we ad wdata         ack req id busy rdata
        // reset values, reserved-bit write, edge pulse on src 1 and its latency
        tbl.push_back(mk(0, 'h00, 0, 0, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 2, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 3, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 1, 0, 'hFFFF_FFC3,  0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 1, 2, 'h3,          0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 0, 0,            0,  0, 0, 0, 'h3));
        tbl.push_back(mk(0, 'h00, 0, 2, 0,            0,  0, 0, 0, 'h3));
        tbl.push_back(mk(0, 'h02, 0, 1, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h2));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            1,  1, 1, 0, 'h2));
        tbl.push_back(mk(0, 'h00, 0, 3, 0,            0,  0, 0, 1, 'h8000_0001));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 1, 'h0));
        tbl.push_back(mk(0, 'h00, 1, 3, 0,            0,  0, 0, 1, 'h8000_0001));
        tbl.push_back(mk(0, 'h00, 0, 3, 0,            0,  0, 0, 0, 'h0));
        // src 0 and 1 together: 0 wins, EOI then 1 requested, w1c withdraws it
        tbl.push_back(mk(0, 'h03, 0, 1, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h3));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            1,  1, 0, 0, 'h3));
        tbl.push_back(mk(0, 'h00, 0, 3, 0,            0,  0, 0, 1, 'h8000_0000));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 1, 'h2));
        tbl.push_back(mk(0, 'h00, 1, 3, 0,            0,  0, 0, 1, 'h8000_0000));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h2));
        tbl.push_back(mk(0, 'h00, 1, 1, 'h2,          0,  1, 1, 0, 'h2));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  1, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h0));
        // level source 2: w1c ignored, dropping the line withdraws the request
        tbl.push_back(mk(0, 'h00, 1, 0, 'h4,          0,  0, 0, 0, 'h3));
        tbl.push_back(mk(0, 'h04, 0, 0, 0,            0,  0, 0, 0, 'h4));
        tbl.push_back(mk(0, 'h04, 0, 1, 0,            0,  0, 0, 0, 'h4));
        tbl.push_back(mk(0, 'h04, 1, 1, 'h4,          0,  1, 2, 0, 'h4));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  1, 2, 0, 'h4));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  1, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 3, 0,            0,  0, 0, 0, 'h0));
        // edge set beats same-cycle w1c; ack beats same-cycle EOI
        tbl.push_back(mk(0, 'h00, 1, 0, 'h3,          0,  0, 0, 0, 'h4));
        tbl.push_back(mk(0, 'h01, 1, 1, 'h1,          0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h1));
        tbl.push_back(mk(0, 'h00, 1, 3, 0,            1,  1, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 3, 0,            0,  0, 0, 1, 'h8000_0000));
        // reset in SERVICE clears everything
        tbl.push_back(mk(1, 'h00, 0, 3, 0,            0,  0, 0, 1, 'h8000_0000));
        tbl.push_back(mk(0, 'h00, 0, 0, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 2, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 3, 0,            0,  0, 0, 0, 'h0));
        // highest index source, then reset while requesting
        tbl.push_back(mk(0, 'h00, 1, 0, 'h3F,         0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 1, 2, 'h3F,         0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h20, 0, 1, 0,            0,  0, 0, 0, 'h0));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h20));
        tbl.push_back(mk(1, 'h00, 0, 1, 0,            0,  1, 5, 0, 'h20));
        tbl.push_back(mk(0, 'h00, 0, 1, 0,            0,  0, 0, 0, 'h0));

        reset         = 1'b1;
        bus.src_irq   = '0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.int_ack   = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Nesting: src 3 in service, src 1 arrives.
        apply(mk(0, 'h00, 1, 0, 'h0A, 0, 0, 0, 0, 'h0), "nest_en");
        apply(mk(0, 'h00, 1, 2, 'h0A, 0, 0, 0, 0, 'h0), "nest_edge");
        apply(mk(0, 'h08, 0, 1, 0,    0, 0, 0, 0, 'h0), "nest_src3");
        apply(mk(0, 'h00, 0, 1, 0,    0, 0, 0, 0, 'h8), "nest_pend3");
        apply(mk(0, 'h00, 0, 1, 0,    1, 1, 3, 0, 'h8), "nest_req3");
        apply(mk(0, 'h00, 0, 3, 0,    0, 0, 0, 1, 'h8000_0003), "nest_cur3");
        apply(mk(0, 'h02, 0, 1, 0,    0, 0, 0, 1, 'h0), "nest_src1");
        apply(mk(0, 'h00, 0, 1, 0,    0, 0, 0, 1, 'h2), "nest_pend1");
`ifdef INTC_NEST_EN
        apply(mk(0, 'h00, 0, 3, 0,    1, 1, 1, 1, 'h8000_0003), "nest_preq");
        apply(mk(0, 'h00, 0, 3, 0,    0, 0, 0, 1, 'h8000_0001), "nest_cur1");
        apply(mk(0, 'h00, 1, 3, 0,    0, 0, 0, 1, 'h8000_0001), "nest_eoi1");
        apply(mk(0, 'h00, 0, 3, 0,    0, 0, 0, 1, 'h8000_0003), "nest_pop");
        apply(mk(0, 'h00, 1, 3, 0,    0, 0, 0, 1, 'h8000_0003), "nest_eoi2");
        apply(mk(0, 'h00, 0, 3, 0,    0, 0, 0, 0, 'h0), "nest_idle");
`else
        apply(mk(0, 'h00, 0, 3, 0,    1, 0, 0, 1, 'h8000_0003), "nopre_ack");
        apply(mk(0, 'h00, 0, 1, 0,    0, 0, 0, 1, 'h2), "nopre_pend");
        apply(mk(0, 'h00, 1, 3, 0,    0, 0, 0, 1, 'h8000_0003), "nopre_eoi");
        apply(mk(0, 'h00, 0, 3, 0,    0, 0, 0, 0, 'h0), "nopre_idle");
        apply(mk(0, 'h00, 1, 3, 0,    0, 1, 1, 0, 'h0), "nopre_req1");
        apply(mk(0, 'h00, 0, 3, 0,    0, 1, 1, 0, 'h0), "nopre_eoi_ign");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
